// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of NREQ requesters onto the
// single register-file write port, plus the busy scoreboard for issue stalls.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int DW   = 28,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_dest,
  output logic                 iss_ready,
  output logic [(1<<AW)-1:0]   busy,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*AW-1:0]   wb_dest,
  input  logic [NREQ*DW-1:0]   wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_dest_sel,
  output logic [DW-1:0]        rf_data_in,
  output logic                 orphan_err
);

  localparam int NREG = 1 << AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [PW-1:0]   ptr_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_n;
  logic            orphan_q;

  logic [PW-1:0]   cand_p0 [NREQ];
  logic            gnt_vld_p0;
  logic [PW-1:0]   gnt_idx_p0;
  logic [AW-1:0]   gnt_dest_p0;
  logic [DW-1:0]   gnt_data_p0;
  logic            iss_set_p0;
  logic            orphan_p0;

  logic            wen_p1;
  logic [AW-1:0]   dest_p1;
  logic [DW-1:0]   data_p1;

  // Stage p0: arbitration, issue acceptance and scoreboard next state
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_p0[k] = PW'((int'(ptr_q) + k + 1) % NREQ);
      if (!gnt_vld_p0 && wb_valid[cand_p0[k]]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand_p0[k];
      end
    end
  end

  always_comb begin
    wb_ready    = '0;
    gnt_dest_p0 = '0;
    gnt_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_p0 == PW'(i)) begin
        wb_ready[i] = gnt_vld_p0;
        gnt_dest_p0 = wb_dest[i*AW +: AW];
        gnt_data_p0 = wb_data[i*DW +: DW];
      end
    end
  end

  assign iss_ready  = iss_valid && !busy_q[iss_dest];
  assign iss_set_p0 = iss_ready && (iss_dest != '0);
  assign orphan_p0  = gnt_vld_p0 && (gnt_dest_p0 != '0) && !busy_q[gnt_dest_p0];

  // A same-cycle set on a register being cleared wins over the clear
  always_comb begin
    busy_n = busy_q;
    if (gnt_vld_p0) busy_n[gnt_dest_p0] = 1'b0;
    if (iss_set_p0) busy_n[iss_dest] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Stage p1: registered write to the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= PTR_RST;
      busy_q   <= '0;
      orphan_q <= 1'b0;
      wen_p1   <= 1'b0;
      dest_p1  <= '0;
      data_p1  <= '0;
    end else begin
      busy_q <= busy_n;
      wen_p1 <= gnt_vld_p0 && (gnt_dest_p0 != '0);
      if (orphan_p0) orphan_q <= 1'b1;
      if (gnt_vld_p0) begin
        ptr_q   <= gnt_idx_p0;
        dest_p1 <= gnt_dest_p0;
        data_p1 <= gnt_data_p0;
      end
    end
  end

  assign busy        = busy_q;
  assign orphan_err  = orphan_q;
  assign rf_wen      = wen_p1;
  assign rf_dest_sel = dest_p1;
  assign rf_data_in  = data_p1;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler; register-file writes are checked by a
// scoreboard monitor, combinational handshakes are checked by the driver.
module tb_rf_wb_scheduler;
  localparam int NREQ = 3;
  localparam int DW   = 28;
  localparam int AW   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_dest = '0;
  logic                iss_ready;
  logic [(1<<AW)-1:0]  busy;
  logic [NREQ-1:0]     wb_valid = '0;
  logic [NREQ*AW-1:0]  wb_dest = '0;
  logic [NREQ*DW-1:0]  wb_data = '0;
  logic [NREQ-1:0]     wb_ready;
  logic                rf_wen;
  logic [AW-1:0]       rf_dest_sel;
  logic [DW-1:0]       rf_data_in;
  logic                orphan_err;

  rf_wb_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .busy(busy),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_wen(rf_wen), .rf_dest_sel(rf_dest_sel), .rf_data_in(rf_data_in),
    .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int  checks = 0;
  int  errors = 0;
  int  cnt[NREQ];
  int  exp_g[7] = '{0, 1, 2, 0, 1, 2, -1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    iss_valid = 1'b0;
    iss_dest  = '0;
    wb_valid  = '0;
    wb_dest   = '0;
    wb_data   = '0;
  endtask

  task automatic set_wb(input int i, input logic [AW-1:0] d, input logic [DW-1:0] v);
    wb_valid[i]          = 1'b1;
    wb_dest[i*AW +: AW]  = d;
    wb_data[i*DW +: DW]  = v;
  endtask

  task automatic push(input logic [AW-1:0] d, input logic [DW-1:0] v);
    wr_t w;
    w.d = d;
    w.v = v;
    exp_q.push_back(w);
  endtask

  function automatic logic [AW-1:0] rr_dest(input int i, input int n);
    return AW'(i + 1 + 3 * n);
  endfunction

  function automatic logic [DW-1:0] rr_data(input int i, input int n);
    return DW'(28'h0A00000 + (i + 1 + 3 * n) * 28'h111);
  endfunction

  // Scoreboard monitor: every register-file write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && rf_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got dest %0d data %0h expected no write",
                 rf_dest_sel, rf_data_in);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_dest", 64'(rf_dest_sel), 64'(mon_w.d));
        chk("wr_data", 64'(rf_data_in), 64'(mon_w.v));
      end
    end
  end

  initial begin
    // Reset pulse mid-cycle takes effect at once
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wen", 64'(rf_wen), 64'h0);
    chk("rst_ready", 64'(wb_ready), 64'h0);
    chk("rst_orphan", 64'(orphan_err), 64'h0);
    chk("rst_dest", 64'(rf_dest_sel), 64'h0);
    chk("rst_data", 64'(rf_data_in), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_wen", 64'(rf_wen), 64'h0);

    // Pre-issue r1..r6 for the round-robin run
    for (int r = 1; r <= 6; r++) begin
      @(negedge clk);
      clr_in();
      iss_valid = 1'b1;
      iss_dest  = AW'(r);
      #1 chk($sformatf("pre_iss%0d", r), 64'(iss_ready), 64'h1);
    end
    @(negedge clk);
    clr_in();
    chk("pre_busy", 64'(busy), 64'h007E);

    // Round-robin with all requesters held
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clr_in();
      for (int i = 0; i < NREQ; i++)
        if (cnt[i] < 2) set_wb(i, rr_dest(i, cnt[i]), rr_data(i, cnt[i]));
      #1;
      if (exp_g[c] >= 0) begin
        chk($sformatf("rr_grant%0d", c), 64'(wb_ready), 64'(1 << exp_g[c]));
        push(rr_dest(exp_g[c], cnt[exp_g[c]]), rr_data(exp_g[c], cnt[exp_g[c]]));
        cnt[exp_g[c]]++;
      end else begin
        chk("rr_none", 64'(wb_ready), 64'h0);
      end
    end
    @(negedge clk);
    clr_in();
    chk("rr_busy", 64'(busy), 64'h0);
    chk("rr_orphan", 64'(orphan_err), 64'h0);

    // Issue / writeback loop on r5
    @(negedge clk);
    iss_valid = 1'b1;
    iss_dest  = 4'd5;
    #1 chk("iss5", 64'(iss_ready), 64'h1);
    @(negedge clk);
    chk("busy5_set", 64'(busy[5]), 64'h1);
    clr_in();
    iss_valid = 1'b1;
    iss_dest  = 4'd5;
    set_wb(1, 4'd5, 28'h0ABCDEF);
    #1;
    chk("iss5_again", 64'(iss_ready), 64'h0);
    chk("wb5_grant", 64'(wb_ready), 64'b010);
    push(4'd5, 28'h0ABCDEF);
    @(negedge clk);
    clr_in();
    chk("busy5_clr", 64'(busy[5]), 64'h0);

    // Register 0: issue always accepted, write accepted and dropped
    @(negedge clk);
    iss_valid = 1'b1;
    iss_dest  = 4'd0;
    set_wb(0, 4'd0, 28'h1234567);
    #1;
    chk("iss_r0", 64'(iss_ready), 64'h1);
    chk("wb_r0_grant", 64'(wb_ready), 64'b001);
    @(negedge clk);
    clr_in();
    chk("r0_busy", 64'(busy), 64'h0);
    chk("r0_wen", 64'(rf_wen), 64'h0);
    chk("r0_orphan", 64'(orphan_err), 64'h0);
    chk("r0_data_cap", 64'(rf_data_in), 64'h1234567);

    // Orphan write to r7
    @(negedge clk);
    set_wb(1, 4'd7, 28'h7777777);
    #1 chk("orph_grant", 64'(wb_ready), 64'b010);
    push(4'd7, 28'h7777777);
    @(negedge clk);
    clr_in();
    chk("orph_set", 64'(orphan_err), 64'h1);
    iss_valid = 1'b1;
    iss_dest  = 4'd9;
    #1 chk("iss9", 64'(iss_ready), 64'h1);

    // Issue and writeback to busy r9 in the same cycle
    @(negedge clk);
    chk("busy9_set", 64'(busy[9]), 64'h1);
    clr_in();
    iss_valid = 1'b1;
    iss_dest  = 4'd9;
    set_wb(2, 4'd9, 28'h0999999);
    #1;
    chk("iss9_refused", 64'(iss_ready), 64'h0);
    chk("wb9_grant", 64'(wb_ready), 64'b100);
    push(4'd9, 28'h0999999);

    // Issue and writeback to non-busy r10 in the same cycle: set wins
    @(negedge clk);
    clr_in();
    chk("busy9_clr", 64'(busy), 64'h0);
    chk("orph_sticky", 64'(orphan_err), 64'h1);
    iss_valid = 1'b1;
    iss_dest  = 4'd10;
    set_wb(0, 4'd10, 28'h0AAAA10);
    #1;
    chk("iss10", 64'(iss_ready), 64'h1);
    chk("wb10_grant", 64'(wb_ready), 64'b001);
    push(4'd10, 28'h0AAAA10);
    @(negedge clk);
    clr_in();
    chk("busy10_setwins", 64'(busy), 64'h0400);
    chk("orph_sticky2", 64'(orphan_err), 64'h1);

    // Reset while a registered write is on the outputs
    @(negedge clk);
    set_wb(1, 4'd10, 28'h0BADBAD);
    #1 chk("rstw_grant", 64'(wb_ready), 64'b010);
    @(posedge clk);
    #1;
    clr_in();
    chk("rstw_wen_up", 64'(rf_wen), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_wen", 64'(rf_wen), 64'h0);
    chk("rstw_busy", 64'(busy), 64'h0);
    chk("rstw_orphan", 64'(orphan_err), 64'h0);
    chk("rstw_dest", 64'(rf_dest_sel), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_wen", 64'(rf_wen), 64'h0);
    chk("post_ready", 64'(wb_ready), 64'h0);
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
